pipeline_stage_ctrl: RTL and testbench

//  Central sequencer for the 5-stage MIPS pipeline (F/D/E/M/W).

---
 rtl/pipeline_stage_ctrl_if.sv | 36 +++
 rtl/pipeline_stage_ctrl.sv | 123 ++++++++++++
 tb/tb_pipeline_stage_ctrl.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/pipeline_stage_ctrl_if.sv
// Handshake bundle between the pipeline sequencer and the hazard unit / stage registers.
// The slave modport is the sequencer side; the master modport is the side that drives its inputs.
interface pipeline_stage_ctrl_if #(
   parameter int unsigned CNT_W = 32
) ();
   logic             load_use;
   logic             redirect;
   logic             M_mem_valid;
   logic             mem_ack;
   logic             E_md_start;
   logic             D_uses_hilo;

   logic             pc_en;
   logic             D_en;
   logic             E_en;
   logic             M_en;
   logic             D_flush;
   logic             E_flush;
   logic             W_bubble;
   logic             mem_req;
   logic             md_busy;
   logic             mem_error;
   logic [CNT_W-1:0] stall_cycles;

   modport master (
      output load_use, redirect, M_mem_valid, mem_ack, E_md_start, D_uses_hilo,
      input  pc_en, D_en, E_en, M_en, D_flush, E_flush, W_bubble, mem_req, md_busy,
      input  mem_error, stall_cycles
   );

   modport slave (
      input  load_use, redirect, M_mem_valid, mem_ack, E_md_start, D_uses_hilo,
      output pc_en, D_en, E_en, M_en, D_flush, E_flush, W_bubble, mem_req, md_busy,
      output mem_error, stall_cycles
   );
endinterface

// File: rtl/pipeline_stage_ctrl.sv
// Central sequencer for the 5-stage pipeline: merges memory wait, redirect, load-use and
// mult/div hazards into per-stage register enables, flushes and a stall-cycle counter.
module pipeline_stage_ctrl #(
   parameter int unsigned MD_LATENCY  = 32,
   parameter int unsigned MEM_TIMEOUT = 64,
   parameter int unsigned CNT_W       = 32
) (
   input logic                  clk,
   input logic                  reset,
   pipeline_stage_ctrl_if.slave bus
);
   localparam int unsigned     WaitW    = $clog2(MEM_TIMEOUT);
   localparam int unsigned     MdW      = $clog2(MD_LATENCY + 1);
   localparam logic [WaitW-1:0] WaitLast = WaitW'(MEM_TIMEOUT - 1);
   localparam logic [MdW-1:0]   MdLoad   = MdW'(MD_LATENCY);

   typedef enum logic [0:0] {StIdle, StWait} mem_state_e;

   mem_state_e       state_q, state_d;
   logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
   logic [MdW-1:0]   md_cnt_q, md_cnt_d;
   logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
   logic             mem_error_q, mem_error_d;
   logic             mem_timeout, mem_freeze, md_busy, md_stall;

   always_comb begin
      mem_timeout = (state_q == StWait) && (wait_cnt_q == WaitLast);
      // The timeout cycle releases the stage even without an ack.
      mem_freeze  = bus.M_mem_valid && !bus.mem_ack && !mem_timeout;
      state_d     = state_q;
      wait_cnt_d  = wait_cnt_q;
      mem_error_d = 1'b0;
      case (state_q)
         StIdle: begin
            if (bus.M_mem_valid && !bus.mem_ack) begin
               state_d    = StWait;
               wait_cnt_d = WaitW'(1);
            end
         end
         StWait: begin
            if (bus.mem_ack || mem_timeout) begin
               state_d     = StIdle;
               wait_cnt_d  = '0;
               mem_error_d = mem_timeout && !bus.mem_ack;
            end else begin
               wait_cnt_d = wait_cnt_q + WaitW'(1);
            end
         end
      endcase
   end

   always_comb begin
      md_busy  = (md_cnt_q != '0);
      md_stall = md_busy && bus.D_uses_hilo;
      md_cnt_d = md_cnt_q;
      if (bus.E_md_start && !mem_freeze) begin
         md_cnt_d = MdLoad;
      end else if (md_busy) begin
         md_cnt_d = md_cnt_q - MdW'(1);
      end
   end

   always_comb begin
      bus.pc_en    = 1'b1;
      bus.D_en     = 1'b1;
      bus.E_en     = 1'b1;
      bus.M_en     = 1'b1;
      bus.D_flush  = 1'b0;
      bus.E_flush  = 1'b0;
      bus.W_bubble = 1'b0;
      if (reset) begin
         bus.pc_en    = 1'b0;
         bus.D_en     = 1'b0;
         bus.E_en     = 1'b0;
         bus.M_en     = 1'b0;
         bus.D_flush  = 1'b1;
         bus.E_flush  = 1'b1;
         bus.W_bubble = 1'b1;
      end else if (mem_freeze) begin
         bus.pc_en    = 1'b0;
         bus.D_en     = 1'b0;
         bus.E_en     = 1'b0;
         bus.M_en     = 1'b0;
         bus.W_bubble = 1'b1;
      end else if (bus.redirect) begin
         // Squashing D makes any pending load-use or HI/LO stall moot.
         bus.D_flush = 1'b1;
         bus.E_flush = 1'b1;
      end else if (bus.load_use || md_stall) begin
         bus.pc_en   = 1'b0;
         bus.D_en    = 1'b0;
         bus.E_flush = 1'b1;
      end
   end

   always_comb begin
      stall_cycles_d = stall_cycles_q;
      if (!bus.pc_en && (stall_cycles_q != '1)) begin
         stall_cycles_d = stall_cycles_q + CNT_W'(1);
      end
   end

   assign bus.mem_req      = bus.M_mem_valid && !reset;
   assign bus.md_busy      = md_busy;
   assign bus.mem_error    = mem_error_q;
   assign bus.stall_cycles = stall_cycles_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= StIdle;
         wait_cnt_q     <= '0;
         md_cnt_q       <= '0;
         stall_cycles_q <= '0;
         mem_error_q    <= 1'b0;
      end else begin
         state_q        <= state_d;
         wait_cnt_q     <= wait_cnt_d;
         md_cnt_q       <= md_cnt_d;
         stall_cycles_q <= stall_cycles_d;
         mem_error_q    <= mem_error_d;
      end
   end
endmodule

// File: tb/tb_pipeline_stage_ctrl.sv
// Directed bench: instance a uses long memory timeout and 32-bit counter, instance b a
// 4-cycle timeout and 2-bit counter to reach the timeout and saturation boundaries.
module tb_pipeline_stage_ctrl;
   logic clk = 1'b0;
   logic reset;
   logic load_use, redirect, M_mem_valid, mem_ack, E_md_start, D_uses_hilo;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   pipeline_stage_ctrl_if #(.CNT_W(32)) bus_a ();
   pipeline_stage_ctrl_if #(.CNT_W(2))  bus_b ();

   assign bus_a.load_use    = load_use;
   assign bus_a.redirect    = redirect;
   assign bus_a.M_mem_valid = M_mem_valid;
   assign bus_a.mem_ack     = mem_ack;
   assign bus_a.E_md_start  = E_md_start;
   assign bus_a.D_uses_hilo = D_uses_hilo;
   assign bus_b.load_use    = load_use;
   assign bus_b.redirect    = redirect;
   assign bus_b.M_mem_valid = M_mem_valid;
   assign bus_b.mem_ack     = mem_ack;
   assign bus_b.E_md_start  = E_md_start;
   assign bus_b.D_uses_hilo = D_uses_hilo;

   pipeline_stage_ctrl #(.MD_LATENCY(3), .MEM_TIMEOUT(64), .CNT_W(32)) u_dut_a (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_a)
   );

   pipeline_stage_ctrl #(.MD_LATENCY(3), .MEM_TIMEOUT(4), .CNT_W(2)) u_dut_b (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_b)
   );

   logic [3:0] en_a, en_b;
   logic [2:0] fl_a, fl_b;
   assign en_a = {bus_a.pc_en, bus_a.D_en, bus_a.E_en, bus_a.M_en};
   assign en_b = {bus_b.pc_en, bus_b.D_en, bus_b.E_en, bus_b.M_en};
   assign fl_a = {bus_a.D_flush, bus_a.E_flush, bus_a.W_bubble};
   assign fl_b = {bus_b.D_flush, bus_b.E_flush, bus_b.W_bubble};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; load_use = 1'b0; redirect = 1'b0; M_mem_valid = 1'b1;
      mem_ack = 1'b0; E_md_start = 1'b0; D_uses_hilo = 1'b0;

      // Reset held for three edges; mem_req must stay low despite M_mem_valid.
      tick();
      #1;
      check("rst_en", 32'(en_a), 32'h0);
      check("rst_flush", 32'(fl_a), 32'h7);
      check("rst_mem_req", 32'(bus_a.mem_req), 32'h0);
      check("rst_md_busy", 32'(bus_a.md_busy), 32'h0);
      check("rst_mem_error", 32'(bus_a.mem_error), 32'h0);
      tick();
      tick();
      check("rst_stall_hold", bus_a.stall_cycles, 32'h0);
      reset = 1'b0; M_mem_valid = 1'b0;
      #1;
      check("run_en", 32'(en_a), 32'hf);
      check("run_flush", 32'(fl_a), 32'h0);
      tick();

      // Load-use stall for one cycle.
      load_use = 1'b1;
      #1;
      check("lu_en", 32'(en_a), 32'h3);
      check("lu_flush", 32'(fl_a), 32'h2);
      tick();
      load_use = 1'b0;
      #1;
      check("lu_stall_cnt", bus_a.stall_cycles, 32'd1);
      check("lu_release_en", 32'(en_a), 32'hf);

      // Memory wait: four unacked cycles then ack.
      M_mem_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         check("memw_en", 32'(en_a), 32'h0);
         check("memw_flush", 32'(fl_a), 32'h1);
         check("memw_req", 32'(bus_a.mem_req), 32'h1);
         tick();
      end
      mem_ack = 1'b1;
      #1;
      check("memw_ack_en", 32'(en_a), 32'hf);
      check("memw_ack_flush", 32'(fl_a), 32'h0);
      check("sat_stall_b", 32'(bus_b.stall_cycles), 32'd3);
      tick();
      M_mem_valid = 1'b0; mem_ack = 1'b0;
      #1;
      check("memw_stall_cnt", bus_a.stall_cycles, 32'd5);
      check("memw_no_error", 32'(bus_a.mem_error), 32'h0);

      // Zero-wait access: ack alongside request, no freeze.
      M_mem_valid = 1'b1; mem_ack = 1'b1;
      #1;
      check("zw_en", 32'(en_a), 32'hf);
      check("zw_req", 32'(bus_a.mem_req), 32'h1);
      tick();
      M_mem_valid = 1'b0; mem_ack = 1'b0;
      #1;
      check("zw_stall_cnt", bus_a.stall_cycles, 32'd5);

      // Timeout on instance b (MEM_TIMEOUT=4).
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      check("to_rst_stall", 32'(bus_b.stall_cycles), 32'd0);
      M_mem_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("to_frozen_en", 32'(en_b), 32'h0);
         check("to_frozen_err", 32'(bus_b.mem_error), 32'h0);
         tick();
      end
      #1;
      check("to_release_en", 32'(en_b), 32'hf);
      check("to_release_flush", 32'(fl_b), 32'h0);
      check("to_release_err", 32'(bus_b.mem_error), 32'h0);
      tick();
      M_mem_valid = 1'b0;
      #1;
      check("to_err_pulse", 32'(bus_b.mem_error), 32'h1);
      check("to_stall_sat", 32'(bus_b.stall_cycles), 32'd3);
      tick();
      check("to_err_clear", 32'(bus_b.mem_error), 32'h0);

      // Mult/div: MD_LATENCY=3, then a HI/LO consumer in D.
      reset = 1'b1;
      tick();
      reset = 1'b0; E_md_start = 1'b1;
      #1;
      check("md_idle_busy", 32'(bus_a.md_busy), 32'h0);
      check("md_start_en", 32'(en_a), 32'hf);
      tick();
      E_md_start = 1'b0; D_uses_hilo = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("md_busy", 32'(bus_a.md_busy), 32'h1);
         check("md_stall_en", 32'(en_a), 32'h3);
         check("md_stall_flush", 32'(fl_a), 32'h2);
         tick();
      end
      #1;
      check("md_done_busy", 32'(bus_a.md_busy), 32'h0);
      check("md_done_en", 32'(en_a), 32'hf);
      D_uses_hilo = 1'b0;

      // Redirect + load-use behind a memory freeze.
      redirect = 1'b1; load_use = 1'b1; M_mem_valid = 1'b1; mem_ack = 1'b0;
      for (int i = 0; i < 2; i++) begin
         #1;
         check("rd_frozen_en", 32'(en_a), 32'h0);
         check("rd_frozen_flush", 32'(fl_a), 32'h1);
         tick();
      end
      mem_ack = 1'b1;
      #1;
      check("rd_en", 32'(en_a), 32'hf);
      check("rd_flush", 32'(fl_a), 32'h6);
      tick();
      redirect = 1'b0; load_use = 1'b0; M_mem_valid = 1'b0; mem_ack = 1'b0;
      #1;
      check("rd_stall_cnt", bus_a.stall_cycles, 32'd5);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
